mem_stage: RTL

//  EX/MEM and MEM/WB pipeline stage fed by the execute stage. Registers alu_out/value_to_write, runs

---
 rtl/cpu_pkg.sv | 14 +
 rtl/dmem_handshake.sv | 65 ++++++
 rtl/mem_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and data-memory handshake state encoding for the CPU pipeline.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_REG_AW  = 4;
    localparam int unsigned DEF_TIMEOUT = 15;
    localparam int unsigned TMO_CNT_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request FSM with ack timeout and sticky error flag.
module dmem_handshake
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic done_c,
    output logic abort_c,
    output logic mem_err
);

    localparam logic [TMO_CNT_W-1:0] CNT_SAT =
        (TIMEOUT == 0) ? '1 : TMO_CNT_W'(TIMEOUT);

    mem_state_e             state_q, state_d;
    logic [TMO_CNT_W-1:0]   cnt_q;
    logic                   hit_c;

    // Abort on the cycle the counter would reach TIMEOUT, so req is high exactly TIMEOUT cycles.
    assign hit_c = (TIMEOUT != 0) && (cnt_q == TMO_CNT_W'(TIMEOUT - 1));
    assign req   = (state_q == ST_REQ);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack) begin
                    done_c  = 1'b1;
                    state_d = start ? ST_REQ : ST_IDLE;
                end else if (hit_c) begin
                    abort_c = 1'b1;
                    state_d = start ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                         cnt_q <= '0;
        else if (start)                                  cnt_q <= '0;
        else if (req && !ack && (cnt_q != CNT_SAT))      cnt_q <= cnt_q + TMO_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)          mem_err <= 1'b0;
        else if (abort_c) mem_err <= 1'b1;
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM and MEM/WB pipeline registers with data-memory access, forwarding taps and stall.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned REG_AW  = DEF_REG_AW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] value_to_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              stall,
    output logic [DATA_W-1:0] exmem_data,
    output logic [REG_AW-1:0] exmem_rd,
    output logic              exmem_fwd_ok,
    output logic              exmem_is_load,
    output logic [DATA_W-1:0] memwb_data,
    output logic [REG_AW-1:0] memwb_rd,
    output logic              wb_en,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_err
);

    logic              em_valid;
    logic              em_mem;
    logic              em_is_store;
    logic              em_rw;
    logic [DATA_W-1:0] em_wdata;
    logic              mem_op_c;
    logic              start_c;
    logic              done_c;
    logic              abort_c;

    // A timeout releases the stall like an ack so the aborted op can leave as a bubble.
    assign mem_op_c = em_valid & em_mem;
    assign stall    = mem_op_c & ~(done_c | abort_c);
    assign start_c  = ~stall & ex_valid & (ex_mem_read | ex_mem_write);

    dmem_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk     (clk),
        .rst     (rst),
        .start   (start_c),
        .ack     (dmem_ack),
        .req     (dmem_req),
        .done_c  (done_c),
        .abort_c (abort_c),
        .mem_err (mem_err)
    );

    assign dmem_we    = dmem_req & em_is_store;
    assign dmem_addr  = {DATA_W{dmem_req}} & exmem_data;
    assign dmem_wdata = {DATA_W{dmem_req}} & em_wdata;

    // EX/MEM: read+write decodes as a store, and stores never write the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            em_valid      <= 1'b0;
            em_mem        <= 1'b0;
            em_is_store   <= 1'b0;
            em_rw         <= 1'b0;
            em_wdata      <= '0;
            exmem_data    <= '0;
            exmem_rd      <= '0;
            exmem_fwd_ok  <= 1'b0;
            exmem_is_load <= 1'b0;
        end else if (!stall) begin
            em_valid      <= ex_valid;
            em_mem        <= ex_mem_read | ex_mem_write;
            em_is_store   <= ex_mem_write;
            em_rw         <= ex_reg_write & ~ex_mem_write;
            em_wdata      <= value_to_write;
            exmem_data    <= alu_out;
            exmem_rd      <= ex_rd;
            exmem_fwd_ok  <= ex_valid & ex_reg_write & ~(ex_mem_read & ~ex_mem_write);
            exmem_is_load <= ex_valid & ex_mem_read & ~ex_mem_write;
        end
    end

    // MEM/WB: bubbles clear wb_en but leave data/rd holding their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en      <= 1'b0;
            memwb_data <= '0;
            memwb_rd   <= '0;
        end else if (stall) begin
            wb_en <= 1'b0;
        end else if (mem_op_c) begin
            if (done_c) begin
                wb_en      <= em_rw;
                memwb_data <= em_is_store ? exmem_data : dmem_rdata;
                memwb_rd   <= exmem_rd;
            end else begin
                wb_en <= 1'b0;
            end
        end else if (em_valid) begin
            wb_en      <= em_rw;
            memwb_data <= exmem_data;
            memwb_rd   <= exmem_rd;
        end else begin
            wb_en <= 1'b0;
        end
    end

endmodule
